// File: rtl/ps2_key_event.sv
// PS/2 keyboard receiver and scancode decoder producing {ext, code} make/break events.
// Optional define PARITY_CHECK_EN: bytes failing odd parity are dropped with frame_err.
module ps2_key_event #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] last_change,
  output logic       key_valid,
  output logic       key_down,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_e;

  logic          clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
  logic          filtClk_q, filtClk_d;
  logic [FW-1:0] filtCnt_q, filtCnt_d;
  logic          bitEdge;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmoCnt_q, tmoCnt_d;
  logic          byteStb_q, byteStb_d;
  logic          rxErr;
`ifdef PARITY_CHECK_EN
  logic          parBit_q, parBit_d;
`endif

  state_e        state_q;
  logic [2:0]    skipCnt_q;
  logic [8:0]    lastChange_q;
  logic          keyDown_q, keyValid_q, frameErr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk;
      clkSync_q  <= clkMeta_q;
      dataMeta_q <= ps2_data;
      dataSync_q <= dataMeta_q;
    end
  end

  // The filtered clock only follows after FILTER_LEN consecutive differing samples.
  always_comb begin
    filtCnt_d = filtCnt_q;
    filtClk_d = filtClk_q;
    if (clkSync_q == filtClk_q) begin
      filtCnt_d = '0;
    end else if (filtCnt_q == FILT_MAX) begin
      filtCnt_d = '0;
      filtClk_d = clkSync_q;
    end else begin
      filtCnt_d = filtCnt_q + 1'b1;
    end
  end

  assign bitEdge = filtClk_q & ~filtClk_d;

  always_comb begin
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tmoCnt_d  = tmoCnt_q;
    byteStb_d = 1'b0;
    rxErr     = 1'b0;
`ifdef PARITY_CHECK_EN
    parBit_d  = parBit_q;
`endif
    if (bitEdge) begin
      tmoCnt_d = '0;
      if (bitCnt_q == 4'd0) begin
        if (!dataSync_q) bitCnt_d = 4'd1;
      end else if (bitCnt_q <= 4'd8) begin
        shift_d  = {dataSync_q, shift_q[7:1]};
        bitCnt_d = bitCnt_q + 4'd1;
      end else if (bitCnt_q == 4'd9) begin
`ifdef PARITY_CHECK_EN
        parBit_d = dataSync_q;
`endif
        bitCnt_d = 4'd10;
      end else begin
        bitCnt_d = 4'd0;
        if (!dataSync_q) rxErr = 1'b1;
`ifdef PARITY_CHECK_EN
        else if (!(^{shift_q, parBit_q})) rxErr = 1'b1;
`endif
        else byteStb_d = 1'b1;
      end
    end else if (bitCnt_q != 4'd0) begin
      // A stalled partial frame is abandoned so the next start bit realigns.
      if (tmoCnt_q == TMO_MAX) begin
        tmoCnt_d = '0;
        bitCnt_d = 4'd0;
        rxErr    = 1'b1;
      end else begin
        tmoCnt_d = tmoCnt_q + 1'b1;
      end
    end else begin
      tmoCnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
      bitCnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      tmoCnt_q  <= '0;
      byteStb_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      parBit_q  <= 1'b0;
`endif
    end else begin
      filtClk_q <= filtClk_d;
      filtCnt_q <= filtCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      tmoCnt_q  <= tmoCnt_d;
      byteStb_q <= byteStb_d;
`ifdef PARITY_CHECK_EN
      parBit_q  <= parBit_d;
`endif
    end
  end

  // Decoder: an error in the same cycle as a byte wins and resets prefix tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      skipCnt_q    <= 3'd0;
      lastChange_q <= 9'h000;
      keyDown_q    <= 1'b0;
      keyValid_q   <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      keyValid_q <= 1'b0;
      frameErr_q <= rxErr;
      if (rxErr) begin
        state_q   <= IDLE;
        skipCnt_q <= 3'd0;
      end else if (byteStb_q) begin
        case (state_q)
          IDLE: begin
            if (shift_q == 8'hE0) begin
              state_q <= EXT;
            end else if (shift_q == 8'hF0) begin
              state_q <= BRK;
            end else if (shift_q == 8'hE1) begin
              state_q   <= PAUSE;
              skipCnt_q <= 3'd7;
            end else if (shift_q != 8'hAA && shift_q != 8'hFA &&
                         shift_q != 8'hFE && shift_q != 8'hEE) begin
              lastChange_q <= {1'b0, shift_q};
              keyDown_q    <= 1'b1;
              keyValid_q   <= 1'b1;
            end
          end
          EXT: begin
            if (shift_q == 8'hF0) begin
              state_q <= EXT_BRK;
            end else if (shift_q != 8'hE0) begin
              lastChange_q <= {1'b1, shift_q};
              keyDown_q    <= 1'b1;
              keyValid_q   <= 1'b1;
              state_q      <= IDLE;
            end
          end
          BRK: begin
            if (shift_q == 8'hE0) begin
              state_q <= EXT;
            end else begin
              lastChange_q <= {1'b0, shift_q};
              keyDown_q    <= 1'b0;
              keyValid_q   <= 1'b1;
              state_q      <= IDLE;
            end
          end
          EXT_BRK: begin
            if (shift_q == 8'hE0) begin
              state_q <= EXT;
            end else begin
              lastChange_q <= {1'b1, shift_q};
              keyDown_q    <= 1'b0;
              keyValid_q   <= 1'b1;
              state_q      <= IDLE;
            end
          end
          PAUSE: begin
            if (skipCnt_q <= 3'd1) begin
              skipCnt_q <= 3'd0;
              state_q   <= IDLE;
            end else begin
              skipCnt_q <= skipCnt_q - 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign last_change = lastChange_q;
  assign key_valid   = keyValid_q;
  assign key_down    = keyDown_q;
  assign frame_err   = frameErr_q;

endmodule
